// File: rtl/sdram_stream_pkg.sv
// sdram_stream_pkg: shared state encoding and defaults for the SDRAM read-stream DMA
package sdram_stream_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 16;
    localparam logic [1:0] RD_MASK = 2'b11;
endpackage

// File: rtl/sdram_resp_fifo.sv
// sdram_resp_fifo: first-word-through FIFO holding read responses until the stream accepts them
module sdram_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = r_count == FULL_CNT;
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd];
    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
    // pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: turns one (address, length) request into SDRAM read commands and streams the responses out
module sdram_stream_reader
    import sdram_stream_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = 16,
    parameter int RESP_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cmd_write,
    input  logic              i_cmd_full,
    output logic              o_cmd_isWrite,
    output logic [ADDR_W-1:0] o_cmd_address,
    output logic [1:0]        o_cmd_writeMask,
    output logic [DATA_W-1:0] o_cmd_writeData,
    output logic              o_cmd_keepOpen,
    input  logic              i_rd_valid,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data
);
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(RESP_DEPTH);
    state_t            r_state;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_exp_addr;
    logic [LEN_W-1:0]  r_issue_left;
    logic [LEN_W-1:0]  r_deliver_left;
    logic [CW-1:0]     r_credits;
    logic              r_err;
    logic              w_start;
    logic              w_run;
    logic              w_issue;
    logic              w_hs;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_err_ev;
    logic [LEN_W-1:0]  w_iss_nxt;
    logic [LEN_W-1:0]  w_del_nxt;
    logic [$clog2(RESP_DEPTH):0] w_unused_count;
    assign w_start         = i_start & (r_state == IDLE);
    assign w_run           = (r_state == ISSUE) | (r_state == DRAIN);
    assign o_cmd_write     = (r_state == ISSUE) & (r_credits != '0) & ~i_cmd_full;
    assign w_issue         = o_cmd_write;
    assign w_hs            = o_out_valid & i_out_ready;
    assign w_iss_nxt       = r_issue_left - LEN_W'(w_issue);
    assign w_del_nxt       = r_deliver_left - LEN_W'(w_hs & w_run);
    assign w_push          = i_rd_valid & w_run & ~w_full;
    assign w_err_ev        = i_rd_valid & (~w_run | w_full | (i_rd_addr != r_exp_addr));
    assign o_busy          = r_state != IDLE;
    assign o_done          = r_state == FINISH;
    assign o_err           = r_err;
    assign o_cmd_isWrite   = 1'b0;
    assign o_cmd_address   = r_next_addr;
    assign o_cmd_writeMask = RD_MASK;
    assign o_cmd_writeData = '0;
    assign o_cmd_keepOpen  = r_state == ISSUE;
    assign o_out_valid     = ~w_empty;
    // request sequencing, address tracking and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_next_addr    <= '0;
            r_exp_addr     <= '0;
            r_issue_left   <= '0;
            r_deliver_left <= '0;
            r_err          <= 1'b0;
        end else begin
            r_err <= (r_err & ~w_start) | w_err_ev;
            if (i_rd_valid) r_exp_addr <= r_exp_addr + ADDR_W'(1);
            case (r_state)
                IDLE: if (i_start) begin
                    r_next_addr    <= i_start_addr;
                    r_exp_addr     <= i_start_addr;
                    r_issue_left   <= i_length;
                    r_deliver_left <= i_length;
                    r_state        <= (i_length != '0) ? ISSUE : FINISH;
                end
                ISSUE: begin
                    if (w_issue) r_next_addr <= r_next_addr + ADDR_W'(1);
                    r_issue_left   <= w_iss_nxt;
                    r_deliver_left <= w_del_nxt;
                    r_state        <= (w_del_nxt == '0) ? FINISH : (w_iss_nxt == '0) ? DRAIN : ISSUE;
                end
                DRAIN: begin
                    r_deliver_left <= w_del_nxt;
                    r_state        <= (w_del_nxt == '0) ? FINISH : DRAIN;
                end
                FINISH: r_state <= IDLE;
            endcase
        end
    end
    // each credit reserves one response slot; the cap guards against stray handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_credits <= CRED_MAX;
        else r_credits <= (w_hs && !w_issue && r_credits == CRED_MAX) ? r_credits
                        : r_credits - CW'(w_issue) + CW'(w_hs);
    end
    sdram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({i_rd_addr, i_rd_data}),
        .i_pop   (w_hs),
        .o_dout  ({o_out_addr, o_out_data}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_count)
    );
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb_sdram_stream_reader: scoreboard bench with a 3-cycle-latency controller model
module tb_sdram_stream_reader;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, err, cmd_write, cmd_isWrite, cmd_keepOpen, out_valid;
    logic          cmd_full = 1'b0;
    logic [AW-1:0] cmd_address, out_addr;
    logic [1:0]    cmd_writeMask;
    logic [DW-1:0] cmd_writeData, out_data;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data = '0;
    logic          out_ready = 1'b1;

    always #5 clk = ~clk;

    sdram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RESP_DEPTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_start_addr    (start_addr),
        .i_length        (length),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_cmd_write     (cmd_write),
        .i_cmd_full      (cmd_full),
        .o_cmd_isWrite   (cmd_isWrite),
        .o_cmd_address   (cmd_address),
        .o_cmd_writeMask (cmd_writeMask),
        .o_cmd_writeData (cmd_writeData),
        .o_cmd_keepOpen  (cmd_keepOpen),
        .i_rd_valid      (rd_valid),
        .i_rd_addr       (rd_addr),
        .i_rd_data       (rd_data),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_addr      (out_addr),
        .o_out_data      (out_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_iss = 0;
    int n_done = 0;
    int cyc = 0;
    logic          full_mode = 1'b0;
    logic          bad_en = 1'b0;
    logic [AW-1:0] bad_from = '0;
    logic [AW-1:0] bad_to = '0;

    typedef struct { int due; logic [AW-1:0] a; } resp_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } word_t;
    resp_t         rq[$];
    word_t         sb[$];
    logic [AW-1:0] eiq[$];

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = a + AW'(i);
            eiq.push_back(w);
            sb.push_back('{w, fdat(w)});
        end
        start_addr = a;
        length = LW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", max);
        end
    endtask

    // controller model: accepts commands, answers each one 3 cycles later in order
    initial begin
        resp_t r;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                rd_valid = 1'b1;
                rd_addr = (bad_en && r.a == bad_from) ? bad_to : r.a;
                rd_data = fdat(r.a);
            end else begin
                rd_valid = 1'b0;
            end
            cmd_full = full_mode & cyc[0];
            @(negedge clk);
            if (rst_n && cmd_write && !cmd_full) begin
                n_iss++;
                if (eiq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue_extra: got address %0h expected no command", cmd_address);
                end else begin
                    chk("issue_addr", 32'(cmd_address), 32'(eiq.pop_front()));
                end
                rq.push_back('{cyc + 3, cmd_address});
            end
        end
    end

    // stream monitor: pops the scoreboard on every handshake and checks hold stability
    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (rst_n && hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(hold_a));
                chk("hold_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_extra: got word %0h:%0h expected none", out_addr, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_addr", 32'(out_addr), 32'(e.a));
                    chk("out_data", 32'(out_data), 32'(e.d));
                end
            end
            hold_v = rst_n && out_valid && !out_ready;
            hold_a = out_addr;
            hold_d = out_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, d0;
        word_t w;
        // reset values
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd_write", 32'(cmd_write), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_credits", 32'(dut.r_credits), 32'd16);
        tick();
        rst_n = 1'b1;
        tick();

        // basic 4-word run, start accepted -> cmd_write next cycle
        i0 = n_iss; d0 = n_done;
        launch(25'h10, 4);
        @(negedge clk);
        chk("latency_cmd_write", 32'(cmd_write), 32'd1);
        chk("cmd_addr_first", 32'(cmd_address), 32'h10);
        chk("cmd_keepopen", 32'(cmd_keepOpen), 32'd1);
        chk("cmd_iswrite", 32'(cmd_isWrite), 32'd0);
        chk("cmd_mask", 32'(cmd_writeMask), 32'd3);
        chk("cmd_wdata", 32'(cmd_writeData), 32'd0);
        wait_done(100);
        repeat (3) tick();
        chk("t1_issues", 32'(n_iss - i0), 32'd4);
        chk("t1_done_once", 32'(n_done - d0), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // credit limit: 40 words with the stream stalled
        out_ready = 1'b0;
        i0 = n_iss; d0 = n_done;
        launch(25'h100, 40);
        repeat (40) tick();
        @(negedge clk);
        chk("t2_stall_issues", 32'(n_iss - i0), 32'd16);
        chk("t2_stall_cmd_write", 32'(cmd_write), 32'd0);
        chk("t2_stall_busy", 32'(busy), 32'd1);
        tick();
        out_ready = 1'b1;
        wait_done(600);
        repeat (3) tick();
        chk("t2_issues", 32'(n_iss - i0), 32'd40);
        chk("t2_done_once", 32'(n_done - d0), 32'd1);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_credits", 32'(dut.r_credits), 32'd16);

        // cmd_full toggling every other cycle
        full_mode = 1'b1;
        i0 = n_iss;
        launch(25'h40, 10);
        wait_done(200);
        full_mode = 1'b0;
        repeat (3) tick();
        chk("t3_issues", 32'(n_iss - i0), 32'd10);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // address wrap at the top of the 25-bit space
        i0 = n_iss;
        launch(25'h1FFFFFE, 4);
        wait_done(100);
        repeat (3) tick();
        chk("t4_issues", 32'(n_iss - i0), 32'd4);
        chk("t4_err", 32'(err), 32'd0);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // zero length: done the cycle after start, no commands
        i0 = n_iss; d0 = n_done;
        launch(25'h55, 0);
        @(negedge clk);
        chk("t5_zero_done", 32'(done), 32'd1);
        chk("t5_zero_cmd_write", 32'(cmd_write), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_zero_idle", 32'(busy), 32'd0);
        chk("t5_zero_issues", 32'(n_iss - i0), 32'd0);
        chk("t5_zero_done_once", 32'(n_done - d0), 32'd1);

        // start while busy is ignored
        i0 = n_iss; d0 = n_done;
        launch(25'h80, 8);
        tick();
        start_addr = 25'h300;
        length = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        repeat (3) tick();
        chk("t5_busy_issues", 32'(n_iss - i0), 32'd8);
        chk("t5_busy_done_once", 32'(n_done - d0), 32'd1);
        chk("t5_busy_sb_empty", 32'(sb.size()), 32'd0);

        // wrong response address: flagged, still forwarded
        bad_en = 1'b1;
        bad_from = 25'h21;
        bad_to = 25'h22;
        launch(25'h20, 4);
        w = sb[1];
        w.a = 25'h22;
        sb[1] = w;
        wait_done(100);
        repeat (3) tick();
        bad_en = 1'b0;
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        // reset mid-run, late responses arrive while idle
        launch(25'h200, 8);
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_err", 32'(err), 32'd0);
        chk("t7_rst_cmd_write", 32'(cmd_write), 32'd0);
        sb.delete();
        eiq.delete();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t7_stray_err", 32'(err), 32'd1);
        chk("t7_out_valid", 32'(out_valid), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        chk("t7_cmd_write", 32'(cmd_write), 32'd0);
        chk("t7_credits", 32'(dut.r_credits), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
